fp_soc_keycode_sched: RTL and testbench

Schedules keycode updates into the 8-bit keycode PIO slave on the SoC bus. Multiple keycode sources (USB HID poller, debug/replay source) request through a round-robin arbiter into a small FIFO. An Avalon-MM master FSM writes each keycode to PIO address 0, holds it for a programmable number of cycles, and writes 0x00 (key release) when no further keycode is queued. It sits between the input sources and the PIO slave port, replacing direct software writes.

---
 rtl/fp_soc_keycode_pkg.sv | 20 ++
 rtl/fp_soc_keycode_fifo.sv | 54 +++++
 rtl/fp_soc_keycode_sched.sv | 200 ++++++++++++++++++++
 tb/tb_fp_soc_keycode_sched.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_soc_keycode_pkg.sv
// Shared types and constants for the keycode PIO scheduler.
// Used by fp_soc_keycode_sched and fp_soc_keycode_fifo.
package fp_soc_keycode_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        HOLD,
        RELEASE,
        VERIFY
    } state_t;

    localparam logic [1:0] PIO_ADDR_KEYCODE = 2'd0;
    localparam logic [7:0] KEY_RELEASE      = 8'h00;

    function automatic logic [31:0] pio_word(input logic [7:0] code);
        return {24'b0, code};
    endfunction

endpackage

// File: rtl/fp_soc_keycode_fifo.sv
// Synchronous keycode FIFO; a push while full is dropped.
// Count is registered so the arbiter sees a stable full flag.
module fp_soc_keycode_fifo
    import fp_soc_keycode_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fp_soc_keycode_sched.sv
// Round-robin keycode arbiter, FIFO and Avalon-MM writer for the keycode PIO.
// Optional readback check enabled by defining KEYCODE_SCHED_READBACK_EN.
module fp_soc_keycode_sched
    import fp_soc_keycode_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int FIFO_DEPTH  = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [8*NUM_REQ-1:0]          req_keycode,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [1:0]                    avm_address,
    output logic                          avm_chipselect,
    output logic                          avm_write_n,
    output logic [31:0]                   avm_writedata,
    input  logic [31:0]                   avm_readdata,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          err
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [PW-1:0] LAST_REQ  = PW'(NUM_REQ - 1);

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] grant;
    logic          grant_valid;
    logic [7:0]    grant_code;
    logic          accept;
    logic          push;
    logic          pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;

    state_t        state, state_n;
    logic [HW-1:0] hold_cnt, hold_n;
    logic          cs_n, wn_n;
    logic [31:0]   wd_n;

    // First valid requester at or after the pointer wins.
    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                grant       = PW'(idx);
                grant_valid = 1'b1;
            end
        end
    end

    assign grant_code = req_keycode[{grant, 3'b000} +: 8];
    assign accept     = grant_valid && !fifo_full && reset_n;
    assign req_ready  = accept ? (NUM_REQ'(1) << grant) : '0;
    // A zero keycode is consumed but never queued.
    assign push       = accept && (grant_code != KEY_RELEASE);

    always_ff @(posedge clk) begin
        if (!reset_n)
            rr_ptr <= '0;
        else if (accept)
            rr_ptr <= (grant == LAST_REQ) ? '0 : grant + 1'b1;
    end

    fp_soc_keycode_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (grant_code),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

`ifdef KEYCODE_SCHED_READBACK_EN
    logic verify_rel, verify_rel_n;
    logic err_q, err_n;
    assign err = err_q;
`else
    logic unused_readdata;
    assign unused_readdata = ^avm_readdata;
    assign err = 1'b0;
`endif

    assign avm_address = PIO_ADDR_KEYCODE;
    assign busy        = (state != IDLE) || !fifo_empty;

    // Bus strobes are computed for the next state and registered with it.
    always_comb begin
        state_n = state;
        hold_n  = hold_cnt;
        pop     = 1'b0;
        cs_n    = 1'b0;
        wn_n    = 1'b1;
        wd_n    = '0;
`ifdef KEYCODE_SCHED_READBACK_EN
        verify_rel_n = verify_rel;
        err_n        = err_q;
`endif
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_n = WRITE;
                    cs_n    = 1'b1;
                    wn_n    = 1'b0;
                    wd_n    = pio_word(fifo_dout);
                end
            end
            WRITE: begin
`ifdef KEYCODE_SCHED_READBACK_EN
                state_n      = VERIFY;
                verify_rel_n = 1'b0;
                cs_n         = 1'b1;
                wd_n         = avm_writedata;
`else
                state_n = HOLD;
                hold_n  = HOLD_LOAD;
`endif
            end
            HOLD: begin
                if (hold_cnt != '0) begin
                    hold_n = hold_cnt - 1'b1;
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_n = WRITE;
                    cs_n    = 1'b1;
                    wn_n    = 1'b0;
                    wd_n    = pio_word(fifo_dout);
                end else begin
                    state_n = RELEASE;
                    cs_n    = 1'b1;
                    wn_n    = 1'b0;
                    wd_n    = pio_word(KEY_RELEASE);
                end
            end
            RELEASE: begin
`ifdef KEYCODE_SCHED_READBACK_EN
                state_n      = VERIFY;
                verify_rel_n = 1'b1;
                cs_n         = 1'b1;
                wd_n         = avm_writedata;
`else
                state_n = IDLE;
`endif
            end
`ifdef KEYCODE_SCHED_READBACK_EN
            VERIFY: begin
                if (avm_readdata != avm_writedata) err_n = 1'b1;
                if (verify_rel) begin
                    state_n = IDLE;
                end else begin
                    state_n = HOLD;
                    hold_n  = HOLD_LOAD;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            hold_cnt       <= '0;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_writedata  <= '0;
`ifdef KEYCODE_SCHED_READBACK_EN
            verify_rel     <= 1'b0;
            err_q          <= 1'b0;
`endif
        end else begin
            state          <= state_n;
            hold_cnt       <= hold_n;
            avm_chipselect <= cs_n;
            avm_write_n    <= wn_n;
            avm_writedata  <= wd_n;
`ifdef KEYCODE_SCHED_READBACK_EN
            verify_rel     <= verify_rel_n;
            err_q          <= err_n;
`endif
        end
    end

endmodule

// File: tb/tb_fp_soc_keycode_sched.sv
// Self-checking bench for fp_soc_keycode_sched: directed scenarios plus
// randomized traffic against a timer/queue reference model.
module tb_fp_soc_keycode_sched;

    localparam int N = 2;
    localparam int D = 8;
    localparam int H = 4;
`ifdef KEYCODE_SCHED_READBACK_EN
    localparam int V = 1;
`else
    localparam int V = 0;
`endif

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [8*N-1:0]  req_keycode = '0;
    logic [N-1:0]    req_ready;
    logic [1:0]      avm_address;
    logic            avm_chipselect;
    logic            avm_write_n;
    logic [31:0]     avm_writedata;
    logic [31:0]     avm_readdata;
    logic            busy;
    logic [3:0]      fifo_count;
    logic            err;

    int errors = 0;
    int checks = 0;

    fp_soc_keycode_sched #(
        .NUM_REQ     (N),
        .FIFO_DEPTH  (D),
        .HOLD_CYCLES (H)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_keycode    (req_keycode),
        .req_ready      (req_ready),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .busy           (busy),
        .fifo_count     (fifo_count),
        .err            (err)
    );

    always #5 clk = ~clk;

    // PIO stub: echoes the last written byte unless told to corrupt it.
    logic [7:0] echo = 8'h00;
    bit corrupt = 1'b0;
    always @(posedge clk)
        if (avm_chipselect && !avm_write_n) echo <= avm_writedata[7:0];
    assign avm_readdata = corrupt ? 32'h0 : {24'h0, echo};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] wq[$];
    int         wt[$];
    always @(negedge clk)
        if (avm_chipselect && !avm_write_n) begin
            wq.push_back(avm_writedata[7:0]);
            wt.push_back(cyc);
        end

    // Reference model: queue of codes, RR pointer, and a slot timer.
    logic [7:0] m_q[$];
    int         m_ptr;
    int         m_timer;
    bit         m_hold;
    bit         m_rel;
    bit         e_cs;
    bit         e_wn;
    logic [7:0] e_wd;

    task automatic model_reset;
        m_q.delete();
        m_ptr = 0; m_timer = 0; m_hold = 0; m_rel = 0;
        e_cs = 0; e_wn = 1; e_wd = 8'h00;
    endtask

    function automatic logic [N-1:0] model_ready(input logic [N-1:0] v);
        logic [N-1:0] r;
        int g;
        r = '0;
        g = -1;
        for (int i = 0; i < N; i++)
            if (g < 0 && v[(m_ptr + i) % N]) g = (m_ptr + i) % N;
        if (g >= 0 && m_q.size() < D) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_write(input logic [7:0] code, input bit rel);
        e_cs = 1; e_wn = 0; e_wd = code;
        m_hold = 1; m_rel = rel;
        m_timer = rel ? 1 + V : H + 1 + V;
    endtask

    task automatic model_edge(input logic [N-1:0] v, input logic [8*N-1:0] k);
        logic [N-1:0] r;
        int g;
        logic [7:0] c;
        r = model_ready(v);
        g = -1;
        for (int i = 0; i < N; i++) if (r[i]) g = i;
        e_cs = 0; e_wn = 1;
        if (!m_hold) begin
            if (m_q.size() > 0) model_write(m_q.pop_front(), 0);
        end else begin
            m_timer--;
            if (m_timer == 0) begin
                if (m_rel) m_hold = 0;
                else if (m_q.size() > 0) model_write(m_q.pop_front(), 0);
                else model_write(8'h00, 1);
            end else if (V == 1 && ((!m_rel && m_timer == H + 1) ||
                                    (m_rel && m_timer == 1))) begin
                e_cs = 1;
            end
        end
        if (g >= 0) begin
            m_ptr = (g + 1) % N;
            c = k[8*g +: 8];
            if (c != 8'h00) m_q.push_back(c);
        end
    endtask

    task automatic test_reset;
        reset_n = 0;
        req_valid = '1;
        req_keycode = {8'h11, 8'h22};
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready !== '0) begin
            errors++; $display("FAIL reset_ready got=%b exp=00", req_ready);
        end
        checks++;
        if (avm_chipselect !== 1'b0 || avm_write_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_bus got cs=%b wn=%b exp cs=0 wn=1",
                     avm_chipselect, avm_write_n);
        end
        checks++;
        if (avm_writedata !== 32'h0 || avm_address !== 2'd0) begin
            errors++;
            $display("FAIL reset_data got wd=%h addr=%0d exp 0",
                     avm_writedata, avm_address);
        end
        checks++;
        if (busy !== 1'b0 || fifo_count !== 4'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_status got busy=%b cnt=%0d err=%b exp 0",
                     busy, fifo_count, err);
        end
        req_valid = '0;
        reset_n = 1;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 300 && busy; i++) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL %s_drain got busy=%b exp=0", name, busy);
        end
    endtask

    task automatic test_single;
        int t0;
        wq.delete(); wt.delete();
        req_valid = 2'b01;
        req_keycode = {8'h00, 8'h1A};
        #1;
        t0 = cyc;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL single_ready got=%b exp=01", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        repeat (12) @(negedge clk);
        checks++;
        if (wq.size() != 2) begin
            errors++; $display("FAIL single_count got=%0d exp=2", wq.size());
        end else begin
            checks++;
            if (wq[0] !== 8'h1A || wt[0] != t0 + 2) begin
                errors++;
                $display("FAIL single_write got=%h@%0d exp=1a@%0d", wq[0], wt[0], t0 + 2);
            end
            checks++;
            if (wq[1] !== 8'h00 || wt[1] != t0 + 7 + 2 * V) begin
                errors++;
                $display("FAIL single_release got=%h@%0d exp=00@%0d",
                         wq[1], wt[1], t0 + 7 + 2 * V);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL single_busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_zero_code;
        wq.delete();
        req_valid = 2'b10;
        req_keycode = {8'h00, 8'h00};
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++; $display("FAIL zero_ready got=%b exp=10", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        checks++;
        if (fifo_count !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_push got cnt=%0d busy=%b exp 0", fifo_count, busy);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (wq.size() != 0) begin
            errors++; $display("FAIL zero_bus got writes=%0d exp=0", wq.size());
        end
        req_valid = 2'b11;
        req_keycode = {8'h55, 8'h44};
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL zero_rrptr got=%b exp=01", req_ready);
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_alternate;
        int gq[$];
        bit bad;
        wq.delete();
        req_valid = 2'b11;
        req_keycode = {8'h05, 8'h04};
        for (int c = 0; c < 30; c++) begin
            #1;
            if (req_ready == 2'b01) gq.push_back(0);
            else if (req_ready == 2'b10) gq.push_back(1);
            @(negedge clk);
        end
        req_valid = '0;
        wait_idle("alt");
        bad = (gq.size() < 4);
        foreach (gq[i]) if (gq[i] != i % 2) bad = 1;
        checks++;
        if (bad) begin
            errors++; $display("FAIL alt_grants got=%p exp=0,1,0,1...", gq);
        end
        checks++;
        if (wq.size() != gq.size() + 1) begin
            errors++;
            $display("FAIL alt_writes got=%0d exp=%0d", wq.size(), gq.size() + 1);
        end else begin
            bad = (wq[wq.size() - 1] !== 8'h00);
            foreach (gq[i]) if (wq[i] !== (gq[i] == 0 ? 8'h04 : 8'h05)) bad = 1;
            checks++;
            if (bad) begin
                errors++; $display("FAIL alt_sequence got=%p", wq);
            end
        end
    endtask

    task automatic test_flood;
        int  sent;
        int  maxc;
        bit  stall;
        bit  bad;
        sent = 0; maxc = 0; stall = 0;
        wq.delete();
        for (int c = 0; c < 300 && sent < 14; c++) begin
            req_valid = 2'b01;
            req_keycode = {8'h00, 8'(8'h30 + sent)};
            #1;
            if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
            if (req_ready[0]) sent++;
            else stall = 1;
            @(negedge clk);
        end
        req_valid = '0;
        if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
        checks++;
        if (sent != 14) begin
            errors++; $display("FAIL flood_sent got=%0d exp=14", sent);
        end
        checks++;
        if (maxc != D || !stall) begin
            errors++;
            $display("FAIL flood_full got max=%0d stall=%b exp max=8 stall=1", maxc, stall);
        end
        wait_idle("flood");
        bad = (wq.size() != 15);
        if (!bad) begin
            for (int i = 0; i < 14; i++) if (wq[i] !== 8'(8'h30 + i)) bad = 1;
            if (wq[14] !== 8'h00) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL flood_order got=%p exp=30..3d,00", wq);
        end
    endtask

    task automatic test_reset_mid;
        wq.delete();
        req_valid = 2'b01;
        req_keycode = {8'h00, 8'h2C};
        @(negedge clk);
        req_valid = '0;
        for (int c = 0; c < 20 && !(avm_chipselect && !avm_write_n); c++)
            @(negedge clk);
        checks++;
        if (avm_writedata !== 32'h2C) begin
            errors++; $display("FAIL mid_write got=%h exp=2c", avm_writedata);
        end
        req_valid = 2'b10;
        req_keycode = {8'h2D, 8'h00};
        @(negedge clk);
        req_valid = '0;
        reset_n = 0;
        @(negedge clk);
        checks++;
        if (avm_chipselect !== 1'b0 || avm_write_n !== 1'b1 ||
            avm_writedata !== 32'h0) begin
            errors++;
            $display("FAIL mid_bus got cs=%b wn=%b wd=%h exp 0/1/0",
                     avm_chipselect, avm_write_n, avm_writedata);
        end
        checks++;
        if (busy !== 1'b0 || fifo_count !== 4'd0 || req_ready !== '0 || err !== 1'b0) begin
            errors++;
            $display("FAIL mid_status got busy=%b cnt=%0d rdy=%b err=%b exp 0",
                     busy, fifo_count, req_ready, err);
        end
        reset_n = 1;
        repeat (12) @(negedge clk);
        checks++;
        if (wq.size() != 1) begin
            errors++; $display("FAIL mid_no_release got writes=%0d exp=1", wq.size());
        end
    endtask

    task automatic test_random;
        logic [N-1:0]   v;
        logic [N-1:0]   exp_r;
        logic [8*N-1:0] k;
        logic [3:0]     ec;
        reset_n = 0;
        req_valid = '0;
        @(negedge clk);
        reset_n = 1;
        model_reset();
        for (int c = 0; c < 500; c++) begin
            checks++;
            if (avm_chipselect !== e_cs || avm_write_n !== e_wn) begin
                errors++;
                $display("FAIL rand_bus c=%0d got cs=%b wn=%b exp cs=%b wn=%b",
                         c, avm_chipselect, avm_write_n, e_cs, e_wn);
            end
            if (e_cs && !e_wn) begin
                checks++;
                if (avm_writedata !== {24'h0, e_wd}) begin
                    errors++;
                    $display("FAIL rand_data c=%0d got=%h exp=%h", c, avm_writedata, e_wd);
                end
            end
            ec = 4'(m_q.size());
            checks++;
            if (fifo_count !== ec || busy !== (m_hold || m_q.size() != 0)) begin
                errors++;
                $display("FAIL rand_status c=%0d got cnt=%0d busy=%b exp cnt=%0d busy=%b",
                         c, fifo_count, busy, ec, (m_hold || m_q.size() != 0));
            end
            checks++;
            if (err !== 1'b0) begin
                errors++; $display("FAIL rand_err c=%0d got=%b exp=0", c, err);
            end
            for (int i = 0; i < N; i++) begin
                v[i] = (c < 250) ? 1'($urandom) : ($urandom_range(0, 7) == 0);
                k[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            end
            req_valid = v;
            req_keycode = k;
            #1;
            exp_r = model_ready(v);
            checks++;
            if (req_ready !== exp_r) begin
                errors++;
                $display("FAIL rand_ready c=%0d got=%b exp=%b", c, req_ready, exp_r);
            end
            model_edge(v, k);
            @(negedge clk);
        end
        req_valid = '0;
        wait_idle("rand");
    endtask

`ifdef KEYCODE_SCHED_READBACK_EN
    task automatic test_readback;
        for (int pass = 0; pass < 2; pass++) begin
            reset_n = 0;
            @(negedge clk);
            reset_n = 1;
            corrupt = (pass == 0);
            req_valid = 2'b01;
            req_keycode = {8'h00, 8'h1A};
            @(negedge clk);
            req_valid = '0;
            wait_idle("rb");
            repeat (5) @(negedge clk);
            checks++;
            if (err !== (pass == 0)) begin
                errors++;
                $display("FAIL rb_err pass=%0d got=%b exp=%b", pass, err, pass == 0);
            end
        end
        corrupt = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_zero_code();
        test_alternate();
        test_flood();
        test_reset_mid();
        test_random();
`ifdef KEYCODE_SCHED_READBACK_EN
        test_readback();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
